// File: rtl/nrisc_pkg.sv
// Shared definitions for the 8-bit nRisc core.
// Holds the opcode map (also used by the control decoder), the instruction
// format classification and the program-loader FSM state type.
package nrisc_pkg;

  localparam logic [2:0] OP_DEFI    = 3'b000;
  localparam logic [2:0] OP_BEQ     = 3'b001;
  localparam logic [2:0] OP_LW      = 3'b010;
  localparam logic [2:0] OP_SW      = 3'b011;
  localparam logic [2:0] OP_MUL     = 3'b100;
  localparam logic [2:0] OP_SUBI    = 3'b101;
  localparam logic [2:0] OP_J       = 3'b110;
  localparam logic [2:0] OP_ENCERRA = 3'b111;

  // I: ra + imm[2:0], R: ra + rb, J: imm[4:0], H: opcode only
  typedef enum logic [1:0] {
    FMT_I,
    FMT_R,
    FMT_J,
    FMT_H
  } instr_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  function automatic instr_fmt_e op_format(input logic [2:0] op);
    instr_fmt_e fmt;
    case (op)
      OP_LW, OP_SW: fmt = FMT_R;
      OP_J:         fmt = FMT_J;
      OP_ENCERRA:   fmt = FMT_H;
      default:      fmt = FMT_I;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/nrisc_instr_encoder.sv
// Combinational packer: decoded instruction fields -> 8-bit nRisc word.
// Ports:
//   op   [2:0] opcode, always placed in word[7:5]
//   ra   [1:0] first register field
//   rb   [1:0] second register field (R-format only)
//   imm  [4:0] immediate / jump target
//   word [7:0] encoded instruction
// Bits not used by the opcode's format are ignored.
module nrisc_instr_encoder
  import nrisc_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic [4:0] imm,
  output logic [7:0] word
);

  always_comb begin
    word      = '0;
    word[7:5] = op;
    case (op_format(op))
      FMT_I: begin
        word[4:3] = ra;
        word[2:0] = imm[2:0];
      end
      FMT_R: begin
        word[4:3] = ra;
        word[2:1] = rb;
      end
      FMT_J: begin
        word[4:0] = imm;
      end
      default: begin
        word[4:0] = '0;
      end
    endcase
  end

endmodule

// File: rtl/nrisc_prog_loader.sv
// Program loader for the nRisc core.
// Accepts decoded instruction fields over a valid/ready stream, encodes them
// and writes them to sequential instruction-memory addresses starting at
// BASE_ADDR. The core is held in reset until a program ending in encerra
// has been fully written.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, (re)starts a load
//   in_valid/in_ready   field stream handshake
//   in_op/ra/rb/imm     instruction fields
//   mem_we/addr/wdata   instruction-memory write port (one-cycle strobe)
//   busy                load in progress
//   done                program complete (sticky until start/reset)
//   error               address space exhausted before encerra (sticky)
//   count               words written in the current load
//   cpu_hold            core reset, released only when done
module nrisc_prog_loader
  import nrisc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [1:0]        in_ra,
  input  logic [1:0]        in_rb,
  input  logic [4:0]        in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count,
  output logic              cpu_hold
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST     = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [7:0]        enc_word;
  logic              xfer;

  nrisc_instr_encoder u_enc (
    .op   (in_op),
    .ra   (in_ra),
    .rb   (in_rb),
    .imm  (in_imm),
    .word (enc_word)
  );

  // start has priority over a transfer in the same cycle, so a restart
  // never lets the coincident word through.
  assign in_ready = (state_q == ST_LOAD) && !start;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;

    if (start) begin
      state_d = ST_LOAD;
      addr_d  = BASE;
      count_d = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else if (xfer) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = addr_q;
      mem_wdata_d = enc_word;
      count_d     = count_q + CNT_ONE;
      addr_d      = addr_q + ADDR_ONE;
      // The halt word and the overflowing word are both written; the
      // wrapped address is never used because ERR accepts nothing.
      if (in_op == OP_ENCERRA) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else if (addr_q == LAST) begin
        state_d = ST_ERR;
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= BASE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign count     = count_q;
  assign busy      = (state_q == ST_LOAD);
  assign cpu_hold  = (state_q != ST_DONE);

endmodule
